psum_requant_writer: RTL and testbench

- Downstream of the 1x64 vector-multiply stage: consumes 64-lane partial-sum vectors (24 b/lane).
- Per lane: optional ReLU, rounding arithmetic right shift, saturation to signed 8 b.
- Writes the resulting 8-bit activation vectors back into the unified buffer at consecutive addresses, so the next layer can read them as input data.
- Controlled by a start/done job interface; valid/ready on input, grant-stalled write port on output.

---
 rtl/psum_requant_writer_if.sv | 34 +++
 rtl/psum_requant_writer.sv | 167 ++++++++++++++++
 tb/tb_psum_requant_writer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_requant_writer_if.sv
// Job control, partial-sum input stream and unified-buffer write port of psum_requant_writer.
// master = job/stream/buffer side, slave = the requantising writer.
interface psum_requant_writer_if #(
    parameter int MATRIX_SIZE    = 64,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int DATA_BW        = 8,
    parameter int ADDRESSSIZE    = 10
);
    logic                                  start;
    logic [ADDRESSSIZE-1:0]                base_addr;
    logic [ADDRESSSIZE-1:0]                num_rows;
    logic [4:0]                            shift;
    logic                                  relu_en;
    logic                                  in_valid;
    logic                                  in_ready;
    logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data;
    logic                                  ub_we;
    logic [ADDRESSSIZE-1:0]                ub_addr;
    logic [DATA_BW*MATRIX_SIZE-1:0]        ub_wdata;
    logic                                  ub_grant;
    logic                                  busy;
    logic                                  done;
    logic                                  sat_flag;

    modport master (
        output start, base_addr, num_rows, shift, relu_en, in_valid, in_data, ub_grant,
        input  in_ready, ub_we, ub_addr, ub_wdata, busy, done, sat_flag
    );

    modport slave (
        input  start, base_addr, num_rows, shift, relu_en, in_valid, in_data, ub_grant,
        output in_ready, ub_we, ub_addr, ub_wdata, busy, done, sat_flag
    );
endinterface

// File: rtl/psum_requant_writer.sv
// Requantises 64-lane partial-sum vectors (ReLU, rounding shift, int8 saturation) and
// writes them to consecutive unified-buffer addresses under a start/done job.
module psum_requant_writer #(
    parameter int MATRIX_SIZE    = 64,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int DATA_BW        = 8,
    parameter int ADDRESSSIZE    = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    psum_requant_writer_if.slave bus
);
    localparam int MS  = MATRIX_SIZE;
    localparam int PSW = PARTIAL_SUM_BW;
    localparam int DBW = DATA_BW;
    localparam int AW  = ADDRESSSIZE;

    localparam logic [4:0]            SMAX    = 5'(PSW - 1);
    localparam logic signed [PSW:0]   SAT_MAX = (PSW+1)'((1 << (DBW - 1)) - 1);
    localparam logic signed [PSW:0]   SAT_MIN = (PSW+1)'(-(1 << (DBW - 1)));

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       base_q, base_d;
    logic [AW-1:0]       rows_q, rows_d;
    logic [4:0]          shift_q, shift_d;
    logic                relu_q, relu_d;
    logic [AW:0]         acc_q, acc_d;
    logic [AW:0]         wr_q, wr_d;
    logic                we_q, we_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DBW*MS-1:0]   wdata_q, wdata_d;
    logic                sat_q, sat_d;

    logic [DBW*MS-1:0]   rq_data;
    logic                rq_sat;
    logic [DBW:0]        lane;
    logic                in_ready;
    logic                accept;
    logic                wr_fire;

    // Returns {clamped, value} for one lane.
    function automatic logic [DBW:0] requant(input logic [PSW-1:0] x,
                                             input logic [4:0] sh,
                                             input logic relu);
        logic [4:0]          s;
        logic signed [PSW:0] v;
        logic signed [PSW:0] rnd;
        logic signed [PSW:0] r;
        logic                sat;
        logic [DBW-1:0]      y;
        s   = (sh > SMAX) ? SMAX : sh;
        v   = {x[PSW-1], x};
        if (relu && v[PSW]) v = '0;
        rnd = (s == 5'd0) ? '0 : ((PSW+1)'(1) << (s - 5'd1));
        r   = (v + rnd) >>> s;
        sat = 1'b0;
        y   = r[DBW-1:0];
        if (r > SAT_MAX) begin
            y   = SAT_MAX[DBW-1:0];
            sat = 1'b1;
        end else if (r < SAT_MIN) begin
            y   = SAT_MIN[DBW-1:0];
            sat = 1'b1;
        end
        return {sat, y};
    endfunction

    always_comb begin
        rq_data = '0;
        rq_sat  = 1'b0;
        lane    = '0;
        for (int unsigned i = 0; i < MS; i++) begin
            lane = requant(bus.in_data[i*PSW +: PSW], shift_q, relu_q);
            rq_data[i*DBW +: DBW] = lane[DBW-1:0];
            rq_sat = rq_sat | lane[DBW];
        end
    end

    // Single-entry output register: may reload in the same cycle its write is granted.
    assign in_ready = (state_q == RUN) && (acc_q < {1'b0, rows_q}) && (!we_q || bus.ub_grant);
    assign accept   = bus.in_valid && in_ready;
    assign wr_fire  = we_q && bus.ub_grant;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        rows_d  = rows_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        acc_d   = acc_q;
        wr_d    = wr_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sat_d   = sat_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d  = bus.base_addr;
                    rows_d  = bus.num_rows;
                    shift_d = bus.shift;
                    relu_d  = bus.relu_en;
                    acc_d   = '0;
                    wr_d    = '0;
                    sat_d   = 1'b0;
                    state_d = (bus.num_rows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (wr_fire && ((wr_q + 1'b1) == {1'b0, rows_q})) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            we_d    = 1'b1;
            addr_d  = base_q + acc_q[AW-1:0];
            wdata_d = rq_data;
            acc_d   = acc_q + 1'b1;
            if (rq_sat) sat_d = 1'b1;
        end else if (wr_fire) begin
            we_d = 1'b0;
        end

        if (wr_fire) wr_d = wr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            base_q  <= '0;
            rows_q  <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            acc_q   <= '0;
            wr_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            rows_q  <= rows_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            acc_q   <= acc_d;
            wr_q    <= wr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.ub_we    = we_q;
    assign bus.ub_addr  = addr_q;
    assign bus.ub_wdata = wdata_q;
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.sat_flag = sat_q;
endmodule

// File: tb/tb_psum_requant_writer.sv
// Bench for psum_requant_writer: arithmetic table, directed corner sequences and
// randomized jobs scored against a plain-arithmetic reference model.
module tb_psum_requant_writer;
    localparam int MS  = 64;
    localparam int PSW = 24;
    localparam int DBW = 8;
    localparam int AW  = 10;
    localparam int IW  = MS * PSW;
    localparam int OW  = MS * DBW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    psum_requant_writer_if #(.MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PSW), .DATA_BW(DBW),
                             .ADDRESSSIZE(AW)) bus ();

    psum_requant_writer #(.MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PSW), .DATA_BW(DBW),
                          .ADDRESSSIZE(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [OW-1:0] data;
    } wr_t;

    typedef struct {
        int x;
        int sh;
        bit relu;
        int y;
        bit sat;
    } arith_t;

    int            vec_cnt = 0;
    int            err_cnt = 0;
    int            cyc = 0;
    wr_t           exp_q[$];
    wr_t           mon_e;
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            last_wr_cyc = -1;
    logic [OW-1:0] last_wdata = '0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [OW-1:0] prev_data = '0;
    logic [IW-1:0] job_vecs[$];
    bit            exp_sat_job;
    int            job_start_cyc;
    arith_t        tbl[$];

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference lane: floor((x + 2^(s-1)) / 2^s) in wide integer arithmetic, then clamp.
    function automatic logic [DBW-1:0] ref_lane(input int x, input int sh, input bit relu,
                                                output bit sat);
        longint v, d, n, q;
        int     s;
        v = x;
        if (relu && v < 0) v = 0;
        s = (sh > PSW - 1) ? PSW - 1 : sh;
        if (s > 0) begin
            d = longint'(1) << s;
            n = v + d / 2;
            q = n / d;
            if ((n % d) != 0 && n < 0) q = q - 1;
            v = q;
        end
        sat = 1'b0;
        if (v > 127) begin v = 127; sat = 1'b1; end
        if (v < -128) begin v = -128; sat = 1'b1; end
        return DBW'(v);
    endfunction

    function automatic logic [OW-1:0] ref_vec(input logic [IW-1:0] v, input int sh,
                                              input bit relu, output bit sat);
        logic [OW-1:0] o;
        bit            ls;
        sat = 1'b0;
        o   = '0;
        for (int i = 0; i < MS; i++) begin
            o[i*DBW +: DBW] = ref_lane(int'($signed(v[i*PSW +: PSW])), sh, relu, ls);
            sat = sat | ls;
        end
        return o;
    endfunction

    function automatic logic [IW-1:0] fill_in(input int x);
        logic [IW-1:0] o;
        logic [PSW-1:0] t;
        t = PSW'(x);
        for (int i = 0; i < MS; i++) o[i*PSW +: PSW] = t;
        return o;
    endfunction

    function automatic logic [OW-1:0] fill_out(input int y);
        logic [OW-1:0] o;
        logic [DBW-1:0] t;
        t = DBW'(y);
        for (int i = 0; i < MS; i++) o[i*DBW +: DBW] = t;
        return o;
    endfunction

    function automatic logic [IW-1:0] rand_vec();
        logic [IW-1:0] o;
        int x;
        for (int i = 0; i < MS; i++) begin
            case ($urandom % 4)
                0:       x = int'($urandom_range(0, 600)) - 300;
                1:       x = int'($urandom);
                2:       x = ($urandom % 2 == 0) ? 8388607 : -8388608;
                default: x = int'($urandom_range(0, 4000)) - 2000;
            endcase
            o[i*PSW +: PSW] = PSW'(x);
        end
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port scoreboard and stall-stability monitor.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_we", OW'(bus.ub_we), OW'(1'b1));
                chk("stall_addr", OW'(bus.ub_addr), OW'(prev_addr));
                chk("stall_data", bus.ub_wdata, prev_data);
            end
            if (bus.ub_we && !bus.ub_grant) chk("stall_ready", OW'(bus.in_ready), OW'(1'b0));
            if (bus.ub_we && bus.ub_grant) begin
                chk("write_expected", OW'(exp_q.size() != 0), OW'(1'b1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", OW'(bus.ub_addr), OW'(mon_e.addr));
                    chk("wr_data", bus.ub_wdata, mon_e.data);
                end
                last_wr_cyc = cyc;
                last_wdata  = bus.ub_wdata;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = bus.ub_we && !bus.ub_grant;
            prev_addr  = bus.ub_addr;
            prev_data  = bus.ub_wdata;
        end
    end

    task automatic run_job(input int base, input int rows, input int sh, input bit relu,
                           input bit rnd_grant, input bit rnd_valid, input bit poke);
        int  k = 0;
        int  n = 0;
        int  pend_k = -1;
        int  dc0;
        int  budget;
        bit  fin = 1'b0;
        bit  vs;
        wr_t e;
        exp_sat_job = 1'b0;
        for (int i = 0; i < rows; i++) begin
            e.addr = AW'((base + i) % (1 << AW));
            e.data = ref_vec(job_vecs[i], sh, relu, vs);
            exp_sat_job = exp_sat_job | vs;
            exp_q.push_back(e);
        end
        dc0 = done_cnt;
        bus.start     = 1'b1;
        bus.base_addr = AW'(base);
        bus.num_rows  = AW'(rows);
        bus.shift     = 5'(sh);
        bus.relu_en   = relu;
        bus.in_valid  = 1'b0;
        bus.ub_grant  = 1'b1;
        job_start_cyc = cyc;
        step();
        bus.start     = 1'b0;
        bus.base_addr = AW'($urandom);
        bus.num_rows  = AW'($urandom);
        bus.shift     = 5'($urandom);
        bus.relu_en   = 1'($urandom);
        budget = rows * 30 + 40;
        while (!fin && n < budget) begin
            bus.in_valid = (k < rows) && (!rnd_valid || ($urandom % 3 != 0));
            if (k < rows) bus.in_data = job_vecs[k];
            bus.ub_grant = !rnd_grant || ($urandom % 3 != 0);
            if (poke) begin
                bus.start     = ($urandom % 3 == 0);
                bus.base_addr = AW'($urandom);
                bus.num_rows  = AW'($urandom);
                bus.shift     = 5'($urandom);
                bus.relu_en   = 1'($urandom);
            end
            @(negedge clk);
            if (pend_k >= 0) begin
                chk("latency_we", OW'(bus.ub_we), OW'(1'b1));
                chk("latency_addr", OW'(bus.ub_addr), OW'((base + pend_k) % (1 << AW)));
                pend_k = -1;
            end
            if (bus.in_valid && bus.in_ready) begin
                pend_k = k;
                k++;
            end
            if (bus.done) begin
                fin = 1'b1;
                bus.start    = 1'b0;
                bus.in_valid = 1'b0;
            end
            n++;
            step();
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        chk("job_done_in_budget", OW'(fin), OW'(1'b1));
        if (rows == 0) chk("done_latency_empty", OW'(done_cyc), OW'(job_start_cyc + 1));
        else           chk("done_after_last_write", OW'(done_cyc), OW'(last_wr_cyc + 1));
        step();
        step();
        chk("done_once", OW'(done_cnt - dc0), OW'(1));
        chk("writes_drained", OW'(exp_q.size()), OW'(0));
        chk("sat_flag", OW'(bus.sat_flag), OW'(exp_sat_job));
        chk("idle_not_busy", OW'(bus.busy), OW'(1'b0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dc0;
        bit  vs;
        wr_t e;
        logic [IW-1:0] va, vb;

        bus.start = 1'b0; bus.base_addr = '0; bus.num_rows = '0; bus.shift = '0;
        bus.relu_en = 1'b0; bus.in_valid = 1'b1; bus.in_data = fill_in(55); bus.ub_grant = 1'b1;

        // Reset held two cycles with in_valid asserted.
        step();
        step();
        @(negedge clk);
        chk("rst_in_ready", OW'(bus.in_ready), OW'(1'b0));
        chk("rst_ub_we", OW'(bus.ub_we), OW'(1'b0));
        chk("rst_busy", OW'(bus.busy), OW'(1'b0));
        chk("rst_done", OW'(bus.done), OW'(1'b0));
        chk("rst_sat", OW'(bus.sat_flag), OW'(1'b0));
        chk("rst_addr", OW'(bus.ub_addr), OW'(0));
        chk("rst_wdata", bus.ub_wdata, '0);
        step();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_in_ready", OW'(bus.in_ready), OW'(1'b0));
            chk("idle_ub_we", OW'(bus.ub_we), OW'(1'b0));
            step();
        end
        bus.in_valid = 1'b0;

        // Three-vector job, full throughput.
        job_vecs = {fill_in(10), fill_in(20), fill_in(30)};
        run_job(5, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("job3_cycles", OW'(done_cyc - job_start_cyc), OW'(5));

        // Arithmetic table.
        tbl.push_back('{100, 4, 1'b0, 6, 1'b0});
        tbl.push_back('{-100, 4, 1'b0, -6, 1'b0});
        tbl.push_back('{5000, 4, 1'b0, 127, 1'b1});
        tbl.push_back('{-5000, 4, 1'b0, -128, 1'b1});
        tbl.push_back('{7, 4, 1'b0, 0, 1'b0});
        tbl.push_back('{8, 4, 1'b0, 1, 1'b0});
        tbl.push_back('{-100, 4, 1'b1, 0, 1'b0});
        tbl.push_back('{-5000, 4, 1'b1, 0, 1'b0});
        tbl.push_back('{5000, 4, 1'b1, 127, 1'b1});
        tbl.push_back('{10, 0, 1'b0, 10, 1'b0});
        tbl.push_back('{200, 0, 1'b0, 127, 1'b1});
        tbl.push_back('{-129, 0, 1'b0, -128, 1'b1});
        tbl.push_back('{-128, 0, 1'b0, -128, 1'b0});
        tbl.push_back('{-3, 1, 1'b0, -1, 1'b0});
        tbl.push_back('{3, 1, 1'b0, 2, 1'b0});
        tbl.push_back('{-8, 4, 1'b0, 0, 1'b0});
        tbl.push_back('{-9, 4, 1'b0, -1, 1'b0});
        tbl.push_back('{2039, 4, 1'b0, 127, 1'b0});
        tbl.push_back('{2047, 4, 1'b0, 127, 1'b1});
        tbl.push_back('{-2056, 4, 1'b0, -128, 1'b0});
        tbl.push_back('{-2057, 4, 1'b0, -128, 1'b1});
        tbl.push_back('{8388607, 31, 1'b0, 1, 1'b0});
        tbl.push_back('{-8388608, 31, 1'b0, -1, 1'b0});
        tbl.push_back('{-8388608, 24, 1'b1, 0, 1'b0});
        for (int i = 0; i < tbl.size(); i++) begin
            job_vecs = {fill_in(tbl[i].x)};
            run_job(300 + i, 1, tbl[i].sh, tbl[i].relu, 1'b0, 1'b0, 1'b0);
            chk("arith_lanes", last_wdata, fill_out(tbl[i].y));
            chk("arith_sat", OW'(bus.sat_flag), OW'(tbl[i].sat));
        end

        // Mixed-lane vector in both ReLU modes.
        va = '0;
        for (int i = 0; i < MS; i++) begin
            case (i % 6)
                0: va[i*PSW +: PSW] = PSW'(100);
                1: va[i*PSW +: PSW] = PSW'(-100);
                2: va[i*PSW +: PSW] = PSW'(5000);
                3: va[i*PSW +: PSW] = PSW'(-5000);
                4: va[i*PSW +: PSW] = PSW'(7);
                default: va[i*PSW +: PSW] = PSW'(8);
            endcase
        end
        job_vecs = {va};
        run_job(40, 1, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(41, 1, 4, 1'b1, 1'b0, 1'b0, 1'b0);

        // Backpressure: four stalled cycles, refill on the grant cycle.
        va = rand_vec();
        vb = rand_vec();
        e.addr = AW'(100); e.data = ref_vec(va, 0, 1'b0, vs); exp_q.push_back(e);
        e.addr = AW'(101); e.data = ref_vec(vb, 0, 1'b0, vs); exp_q.push_back(e);
        dc0 = done_cnt;
        bus.start = 1'b1; bus.base_addr = AW'(100); bus.num_rows = AW'(2); bus.shift = '0;
        bus.relu_en = 1'b0; bus.ub_grant = 1'b0; bus.in_valid = 1'b1; bus.in_data = va;
        step();
        bus.start = 1'b0;
        @(negedge clk);
        chk("bp_first_ready", OW'(bus.in_ready), OW'(1'b1));
        step();
        bus.in_data = vb;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_we_held", OW'(bus.ub_we), OW'(1'b1));
            chk("bp_ready_stalled", OW'(bus.in_ready), OW'(1'b0));
            step();
        end
        bus.ub_grant = 1'b1;
        @(negedge clk);
        chk("bp_refill_ready", OW'(bus.in_ready), OW'(1'b1));
        chk("bp_addr0", OW'(bus.ub_addr), OW'(100));
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_we1", OW'(bus.ub_we), OW'(1'b1));
        chk("bp_addr1", OW'(bus.ub_addr), OW'(101));
        step();
        for (int i = 0; i < 10 && (done_cnt == dc0); i++) step();
        step();
        chk("bp_done_once", OW'(done_cnt - dc0), OW'(1));
        chk("bp_drained", OW'(exp_q.size()), OW'(0));

        // Address wrap, empty job, start ignored while running.
        job_vecs = {rand_vec(), rand_vec()};
        run_job(1023, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        job_vecs = {};
        run_job(9, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        job_vecs = {rand_vec(), rand_vec(), rand_vec(), rand_vec()};
        run_job(200, 4, 3, 1'b1, 1'b1, 1'b1, 1'b1);

        // Abort: reset while a write is stalled.
        dc0 = done_cnt;
        bus.start = 1'b1; bus.base_addr = AW'(50); bus.num_rows = AW'(3); bus.shift = '0;
        bus.relu_en = 1'b0; bus.ub_grant = 1'b0; bus.in_valid = 1'b1; bus.in_data = rand_vec();
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.ub_we) break;
            step();
        end
        chk("abort_we_pending", OW'(bus.ub_we), OW'(1'b1));
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("abort_we_dropped", OW'(bus.ub_we), OW'(1'b0));
        chk("abort_idle", OW'(bus.busy), OW'(1'b0));
        chk("abort_ready", OW'(bus.in_ready), OW'(1'b0));
        bus.in_valid = 1'b0;
        bus.ub_grant = 1'b1;
        step(); step(); step();
        chk("abort_no_done", OW'(done_cnt - dc0), OW'(0));
        job_vecs = {rand_vec(), rand_vec()};
        run_job(7, 2, 5, 1'b0, 1'b1, 1'b0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 10; j++) begin
            int rows;
            rows = int'($urandom_range(1, 6));
            job_vecs = {};
            for (int i = 0; i < rows; i++) job_vecs.push_back(rand_vec());
            run_job(int'($urandom % 1024), rows, int'($urandom % 32), 1'($urandom),
                    1'b1, 1'b1, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
